// File: rtl/saturn_bus_seq_pkg.sv
// Shared encodings for the Saturn bus sequencer: bus command codes,
// request opcodes, FSM states and the read-return tag.
package saturn_bus_seq_pkg;

  typedef enum logic [3:0] {
    CMD_PC_READ     = 4'h0,
    CMD_PC_WRITE    = 4'h1,
    CMD_DP_READ     = 4'h2,
    CMD_DP_WRITE    = 4'h3,
    CMD_LOAD_PC     = 4'h4,
    CMD_LOAD_DP     = 4'h5,
    CMD_CONFIGURE   = 4'h6,
    CMD_UNCONFIGURE = 4'h7,
    CMD_RESET       = 4'h9
  } bus_cmd_e;

  typedef enum logic [2:0] {
    OP_JUMP   = 3'd0,
    OP_DREAD  = 3'd1,
    OP_DWRITE = 3'd2,
    OP_CONFIG = 3'd3,
    OP_RESET  = 3'd4
  } req_op_e;

  typedef enum logic [2:0] {
    ST_RESTORE,
    ST_FETCH,
    ST_CMD1,
    ST_ADDR,
    ST_CMD2,
    ST_DATA
  } state_e;

  // Tags a strobe cycle so the sampled bus nibble goes to the right consumer.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_FETCH,
    RD_DATA
  } rd_kind_e;

  function automatic bus_cmd_e first_cmd(input logic [2:0] op);
    case (op)
      OP_JUMP:             first_cmd = CMD_LOAD_PC;
      OP_DREAD, OP_DWRITE: first_cmd = CMD_LOAD_DP;
      OP_CONFIG:           first_cmd = CMD_CONFIGURE;
      default:             first_cmd = CMD_RESET;
    endcase
  endfunction

endpackage

// File: rtl/saturn_bus_ptr.sv
// Bus-side address pointer with parallel load and modulo-2**AW increment;
// one instance tracks pc, another dp.
module saturn_bus_ptr #(
  parameter int AW = 20
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_load)     ptr_d = i_load_val;
    else if (i_inc) ptr_d = ptr_q + AW'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/saturn_bus_seq.sv
// Saturn bus sequencer: streams PC_READ fetches and runs transfer requests
// as command/address/data nibble sequences on the 4-bit bus.
//   state   | meaning
//   RESTORE | send PC_READ, then resume fetching
//   FETCH   | stream instruction nibbles, accept requests
//   CMD1    | first command (LOAD_PC / LOAD_DP / CONFIGURE / RESET)
//   ADDR    | address nibbles, LSB first
//   CMD2    | DP_READ or DP_WRITE
//   DATA    | data nibble transfers
module saturn_bus_seq
  import saturn_bus_seq_pkg::*;
#(
  parameter  int ADDR_NIBBLES = 5,
  parameter  int MAX_BURST    = 16,
  parameter  int LW           = 5,
  localparam int AW           = 4 * ADDR_NIBBLES
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_bus_slot,
  input  logic          i_req,
  output logic          o_req_ready,
  input  logic [2:0]    i_req_op,
  input  logic [AW-1:0] i_req_addr,
  input  logic [LW-1:0] i_req_len,
  output logic          o_req_err,
  output logic          o_busy,
  output logic          o_done,
  input  logic [3:0]    i_wr_nibble,
  output logic          o_wr_pop,
  output logic [3:0]    o_rd_nibble,
  output logic          o_rd_valid,
  input  logic          i_fetch_ready,
  output logic [3:0]    o_fetch_nibble,
  output logic          o_fetch_valid,
  output logic [AW-1:0] o_pc,
  output logic [AW-1:0] o_dp,
  input  logic [3:0]    i_bus_data,
  output logic [3:0]    o_bus_data,
  output logic          o_bus_strobe,
  output logic          o_bus_cmd_data
);

  localparam int ACW = (ADDR_NIBBLES > 1) ? $clog2(ADDR_NIBBLES) : 1;
  localparam logic [ACW-1:0] LAST_ADDR = ACW'(ADDR_NIBBLES - 1);
  localparam logic [LW-1:0]  MAX_LEN   = LW'(MAX_BURST);

  state_e         state_q, state_d;
  logic [2:0]     op_q;
  logic [AW-1:0]  addr_q;
  logic [LW-1:0]  len_q;
  logic [ACW-1:0] acnt_q, acnt_d;
  logic [LW-1:0]  dcnt_q, dcnt_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           strobe_q, strobe_d, cmd_data_q, cmd_data_d;
  logic [3:0]     bdata_q, bdata_d;
  rd_kind_e       kind_q, kind_d;
  logic           fetch_valid_q, rd_valid_q;
  logic [3:0]     fetch_nib_q, rd_nib_q;
  logic           pc_load, pc_inc, dp_load, dp_inc, wr_pop;
  logic           req_legal, accept, reject, last_addr, last_data, is_write;
  logic [3:0]     addr_nib;

  always_comb begin
    case (i_req_op)
      OP_JUMP, OP_CONFIG, OP_RESET: req_legal = 1'b1;
      OP_DREAD, OP_DWRITE:          req_legal = (i_req_len != '0) && (i_req_len <= MAX_LEN);
      default:                      req_legal = 1'b0;
    endcase
  end

  assign accept    = i_req && (state_q == ST_FETCH) && req_legal;
  assign reject    = i_req && (state_q == ST_FETCH) && !req_legal;
  assign last_addr = (acnt_q == LAST_ADDR);
  assign last_data = (dcnt_q == LW'(1));
  assign is_write  = (op_q == OP_DWRITE);
  assign addr_nib  = 4'(addr_q >> {acnt_q, 2'b00});

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_RESTORE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESTORE: if (i_bus_slot) state_d = ST_FETCH;
      ST_FETCH:   if (accept) state_d = ST_CMD1;
      ST_CMD1:    if (i_bus_slot) state_d = (op_q == OP_RESET) ? ST_RESTORE : ST_ADDR;
      ST_ADDR: begin
        if (i_bus_slot && last_addr) begin
          if (op_q == OP_JUMP)        state_d = ST_FETCH;
          else if (op_q == OP_CONFIG) state_d = ST_RESTORE;
          else                        state_d = ST_CMD2;
        end
      end
      ST_CMD2:    if (i_bus_slot) state_d = ST_DATA;
      ST_DATA:    if (i_bus_slot && last_data) state_d = ST_RESTORE;
      default:    state_d = ST_RESTORE;
    endcase
  end

  always_comb begin
    strobe_d   = 1'b0;
    bdata_d    = 4'h0;
    cmd_data_d = 1'b1;
    kind_d     = RD_NONE;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    dp_load    = 1'b0;
    dp_inc     = 1'b0;
    wr_pop     = 1'b0;
    acnt_d     = acnt_q;
    dcnt_d     = dcnt_q;
    case (state_q)
      ST_RESTORE: begin
        if (i_bus_slot) begin
          strobe_d   = 1'b1;
          bdata_d    = CMD_PC_READ;
          cmd_data_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (accept) acnt_d = '0;
        else if (i_bus_slot && i_fetch_ready) begin
          strobe_d = 1'b1;
          kind_d   = RD_FETCH;
          pc_inc   = 1'b1;
        end
      end
      ST_CMD1: begin
        if (i_bus_slot) begin
          strobe_d   = 1'b1;
          bdata_d    = first_cmd(op_q);
          cmd_data_d = 1'b0;
          acnt_d     = '0;
        end
      end
      ST_ADDR: begin
        if (i_bus_slot) begin
          strobe_d = 1'b1;
          bdata_d  = addr_nib;
          acnt_d   = acnt_q + ACW'(1);
          if (last_addr) begin
            pc_load = (op_q == OP_JUMP);
            dp_load = (op_q == OP_DREAD) || (op_q == OP_DWRITE);
          end
        end
      end
      ST_CMD2: begin
        if (i_bus_slot) begin
          strobe_d   = 1'b1;
          bdata_d    = is_write ? CMD_DP_WRITE : CMD_DP_READ;
          cmd_data_d = 1'b0;
          dcnt_d     = len_q;
        end
      end
      ST_DATA: begin
        if (i_bus_slot) begin
          strobe_d = 1'b1;
          dp_inc   = 1'b1;
          dcnt_d   = dcnt_q - LW'(1);
          if (is_write) begin
            wr_pop  = 1'b1;
            bdata_d = i_wr_nibble;
          end else begin
            kind_d  = RD_DATA;
          end
        end
      end
      default: ;
    endcase
  end

  // Entering FETCH closes out a request; the post-reset RESTORE has busy low, so no done.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = reject;
    if (accept) busy_d = 1'b1;
    else if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
      busy_d = 1'b0;
      done_d = busy_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      acnt_q        <= '0;
      dcnt_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      strobe_q      <= 1'b0;
      cmd_data_q    <= 1'b1;
      bdata_q       <= 4'h0;
      kind_q        <= RD_NONE;
      fetch_valid_q <= 1'b0;
      fetch_nib_q   <= 4'h0;
      rd_valid_q    <= 1'b0;
      rd_nib_q      <= 4'h0;
    end else begin
      if (accept) begin
        op_q   <= i_req_op;
        addr_q <= i_req_addr;
        len_q  <= i_req_len;
      end
      acnt_q        <= acnt_d;
      dcnt_q        <= dcnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      strobe_q      <= strobe_d;
      cmd_data_q    <= cmd_data_d;
      bdata_q       <= bdata_d;
      kind_q        <= kind_d;
      fetch_valid_q <= strobe_q && (kind_q == RD_FETCH);
      rd_valid_q    <= strobe_q && (kind_q == RD_DATA);
      if (strobe_q && (kind_q == RD_FETCH)) fetch_nib_q <= i_bus_data;
      if (strobe_q && (kind_q == RD_DATA))  rd_nib_q    <= i_bus_data;
    end
  end

  saturn_bus_ptr #(.AW(AW)) u_pc (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (pc_load),
    .i_load_val (addr_q),
    .i_inc      (pc_inc),
    .o_ptr      (o_pc)
  );

  saturn_bus_ptr #(.AW(AW)) u_dp (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (dp_load),
    .i_load_val (addr_q),
    .i_inc      (dp_inc),
    .o_ptr      (o_dp)
  );

  assign o_req_ready    = (state_q == ST_FETCH);
  assign o_req_err      = err_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_wr_pop       = wr_pop;
  assign o_rd_nibble    = rd_nib_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_fetch_nibble = fetch_nib_q;
  assign o_fetch_valid  = fetch_valid_q;
  assign o_bus_data     = bdata_q;
  assign o_bus_strobe   = strobe_q;
  assign o_bus_cmd_data = cmd_data_q;

endmodule

// File: tb/tb_saturn_bus_seq.sv
// Directed bench for saturn_bus_seq: each task drives one scenario and
// compares bus nibble sequences, pulses and pointers against hand-derived values.
module tb_saturn_bus_seq;

  logic        i_clk = 1'b0;
  logic        i_reset, i_bus_slot, i_req, i_fetch_ready;
  logic [2:0]  i_req_op;
  logic [19:0] i_req_addr;
  logic [4:0]  i_req_len;
  logic [3:0]  i_wr_nibble, i_bus_data;
  logic        o_req_ready, o_req_err, o_busy, o_done, o_wr_pop, o_rd_valid, o_fetch_valid;
  logic        o_bus_strobe, o_bus_cmd_data;
  logic [3:0]  o_rd_nibble, o_fetch_nibble, o_bus_data;
  logic [19:0] o_pc, o_dp;

  int checks = 0;
  int passed = 0;

  logic [4:0] bus_log[$];
  logic [3:0] fetch_log[$];
  logic [3:0] rd_log[$];
  logic [3:0] wr_q[$];
  logic [3:0] rd_q[$];
  int         done_cnt, err_cnt, pop_cnt;
  logic       rd_armed = 1'b0;

  saturn_bus_seq dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_bus_slot(i_bus_slot),
    .i_req(i_req), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len), .o_req_err(o_req_err),
    .o_busy(o_busy), .o_done(o_done), .i_wr_nibble(i_wr_nibble), .o_wr_pop(o_wr_pop),
    .o_rd_nibble(o_rd_nibble), .o_rd_valid(o_rd_valid), .i_fetch_ready(i_fetch_ready),
    .o_fetch_nibble(o_fetch_nibble), .o_fetch_valid(o_fetch_valid),
    .o_pc(o_pc), .o_dp(o_dp), .i_bus_data(i_bus_data), .o_bus_data(o_bus_data),
    .o_bus_strobe(o_bus_strobe), .o_bus_cmd_data(o_bus_cmd_data)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_bus_strobe)  bus_log.push_back({o_bus_cmd_data, o_bus_data});
    if (o_fetch_valid) fetch_log.push_back(o_fetch_nibble);
    if (o_rd_valid)    rd_log.push_back(o_rd_nibble);
    if (o_done)        done_cnt++;
    if (o_req_err)     err_cnt++;
    if (o_wr_pop)      pop_cnt++;
  end

  // Advance to the next falling edge and play the memory side of the bus.
  task automatic step();
    @(negedge i_clk);
    if (o_wr_pop) begin
      if (wr_q.size() > 0) i_wr_nibble = wr_q.pop_front();
      else                 i_wr_nibble = 4'h0;
    end
    if (rd_armed && o_bus_strobe && o_bus_cmd_data && rd_q.size() > 0) i_bus_data = rd_q.pop_front();
    if (o_bus_strobe && !o_bus_cmd_data) rd_armed = (o_bus_data == 4'h2);
  endtask

  task automatic clear_logs();
    bus_log.delete(); fetch_log.delete(); rd_log.delete();
    done_cnt = 0; err_cnt = 0; pop_cnt = 0;
  endtask

  task automatic run_req(input logic [2:0] op, input logic [19:0] addr,
                         input logic [4:0] len, output bit finished);
    i_req = 1'b1; i_req_op = op; i_req_addr = addr; i_req_len = len;
    step();
    i_req = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 80 && !finished; i++) begin
      step();
      if (o_done) finished = 1'b1;
    end
    step(); step();
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (o_bus_strobe !== 1'b0)   $display("FAIL reset_strobe: got %b want 0", o_bus_strobe);   else passed++;
    checks++; if (o_bus_cmd_data !== 1'b1) $display("FAIL reset_cmd_data: got %b want 1", o_bus_cmd_data); else passed++;
    checks++; if (o_bus_data !== 4'h0)     $display("FAIL reset_bus_data: got %h want 0", o_bus_data);   else passed++;
    checks++; if (o_pc !== 20'h0)          $display("FAIL reset_pc: got %h want 0", o_pc);               else passed++;
    checks++; if (o_dp !== 20'h0)          $display("FAIL reset_dp: got %h want 0", o_dp);               else passed++;
    checks++; if (o_busy !== 1'b0)         $display("FAIL reset_busy: got %b want 0", o_busy);           else passed++;
    checks++; if (o_req_ready !== 1'b0)    $display("FAIL reset_ready: got %b want 0", o_req_ready);     else passed++;
    checks++; if (o_done !== 1'b0 || o_fetch_valid !== 1'b0 || o_rd_valid !== 1'b0)
      $display("FAIL reset_pulses: got done=%b fv=%b rv=%b want 0", o_done, o_fetch_valid, o_rd_valid); else passed++;
  endtask

  task automatic test_fetch_stall();
    clear_logs();
    i_reset = 1'b0;
    step(); step(); step(); step();
    checks++; if (o_pc !== 20'h3) $display("FAIL fetch_pc3: got %h want 3", o_pc); else passed++;
    i_fetch_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (o_pc !== 20'h3) $display("FAIL stall_pc: got %h want 3", o_pc); else passed++;
    checks++; if (bus_log.size() != 4) $display("FAIL fetch_strobes: got %0d want 4", bus_log.size()); else passed++;
    if (bus_log.size() == 4) begin
      checks++; if (bus_log[0] !== 5'h00) $display("FAIL fetch_pc_read: got %h want 00", bus_log[0]); else passed++;
      for (int k = 1; k < 4; k++) begin
        checks++; if (bus_log[k] !== 5'h10) $display("FAIL fetch_read%0d: got %h want 10", k, bus_log[k]); else passed++;
      end
    end
    checks++; if (fetch_log.size() != 3) $display("FAIL fetch_valids: got %0d want 3", fetch_log.size()); else passed++;
    for (int k = 0; k < fetch_log.size(); k++) begin
      checks++; if (fetch_log[k] !== 4'h6) $display("FAIL fetch_nib%0d: got %h want 6", k, fetch_log[k]); else passed++;
    end
    i_bus_slot = 1'b0; i_fetch_ready = 1'b1;
    step(); step(); step();
    checks++; if (o_pc !== 20'h3 || bus_log.size() != 4)
      $display("FAIL no_slot: got pc=%h strobes=%0d want pc=3 strobes=4", o_pc, bus_log.size()); else passed++;
    i_bus_slot = 1'b1; i_fetch_ready = 1'b0;
    step();
  endtask

  task automatic test_jump();
    logic [4:0] exp[$];
    bit fin;
    exp = '{5'h04, 5'h13, 5'h1B, 5'h12, 5'h1A, 5'h11};
    clear_logs();
    run_req(3'd0, 20'h1A2B3, 5'd0, fin);
    checks++; if (!fin) $display("FAIL jump_timeout: got no done want done"); else passed++;
    checks++; if (bus_log.size() != exp.size()) $display("FAIL jump_len: got %0d want %0d", bus_log.size(), exp.size()); else passed++;
    for (int k = 0; k < exp.size() && k < bus_log.size(); k++) begin
      checks++; if (bus_log[k] !== exp[k]) $display("FAIL jump_nib%0d: got %h want %h", k, bus_log[k], exp[k]); else passed++;
    end
    checks++; if (o_pc !== 20'h1A2B3) $display("FAIL jump_pc: got %h want 1a2b3", o_pc); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL jump_done: got %0d want 1", done_cnt); else passed++;
    checks++; if (o_busy !== 1'b0) $display("FAIL jump_busy: got %b want 0", o_busy); else passed++;
    i_fetch_ready = 1'b1; step(); i_fetch_ready = 1'b0; step();
    checks++; if (o_pc !== 20'h1A2B4) $display("FAIL jump_fetch_pc: got %h want 1a2b4", o_pc); else passed++;
  endtask

  task automatic test_dwrite();
    logic [4:0] exp[$];
    bit fin;
    exp = '{5'h05, 5'h10, 5'h10, 5'h11, 5'h10, 5'h10, 5'h03, 5'h17, 5'h18, 5'h19, 5'h00};
    clear_logs();
    wr_q = '{4'h7, 4'h8, 4'h9};
    run_req(3'd2, 20'h00100, 5'd3, fin);
    checks++; if (!fin) $display("FAIL dwrite_timeout: got no done want done"); else passed++;
    checks++; if (bus_log.size() != exp.size()) $display("FAIL dwrite_len: got %0d want %0d", bus_log.size(), exp.size()); else passed++;
    for (int k = 0; k < exp.size() && k < bus_log.size(); k++) begin
      checks++; if (bus_log[k] !== exp[k]) $display("FAIL dwrite_nib%0d: got %h want %h", k, bus_log[k], exp[k]); else passed++;
    end
    checks++; if (pop_cnt != 3) $display("FAIL dwrite_pops: got %0d want 3", pop_cnt); else passed++;
    checks++; if (o_dp !== 20'h00103) $display("FAIL dwrite_dp: got %h want 00103", o_dp); else passed++;
    checks++; if (o_pc !== 20'h1A2B4) $display("FAIL dwrite_pc: got %h want 1a2b4", o_pc); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL dwrite_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_dread();
    logic [4:0] exp[$];
    bit fin;
    exp = '{5'h05, 5'h10, 5'h10, 5'h12, 5'h10, 5'h10, 5'h02, 5'h10, 5'h10, 5'h00};
    clear_logs();
    rd_q = '{4'hC, 4'hD};
    run_req(3'd1, 20'h00200, 5'd2, fin);
    checks++; if (!fin) $display("FAIL dread_timeout: got no done want done"); else passed++;
    checks++; if (bus_log.size() != exp.size()) $display("FAIL dread_len: got %0d want %0d", bus_log.size(), exp.size()); else passed++;
    for (int k = 0; k < exp.size() && k < bus_log.size(); k++) begin
      checks++; if (bus_log[k] !== exp[k]) $display("FAIL dread_nib%0d: got %h want %h", k, bus_log[k], exp[k]); else passed++;
    end
    checks++; if (rd_log.size() != 2) $display("FAIL dread_valids: got %0d want 2", rd_log.size()); else passed++;
    if (rd_log.size() == 2) begin
      checks++; if (rd_log[0] !== 4'hC || rd_log[1] !== 4'hD)
        $display("FAIL dread_data: got %h,%h want c,d", rd_log[0], rd_log[1]); else passed++;
    end
    checks++; if (o_dp !== 20'h00202) $display("FAIL dread_dp: got %h want 00202", o_dp); else passed++;
    i_fetch_ready = 1'b1; step(); i_fetch_ready = 1'b0; step();
    checks++; if (o_pc !== 20'h1A2B5) $display("FAIL dread_resume_pc: got %h want 1a2b5", o_pc); else passed++;
  endtask

  task automatic test_config_reset_ops();
    logic [4:0] exp[$];
    bit fin;
    exp = '{5'h06, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11, 5'h00};
    clear_logs();
    run_req(3'd3, 20'h12345, 5'd0, fin);
    checks++; if (bus_log.size() != exp.size()) $display("FAIL config_len: got %0d want %0d", bus_log.size(), exp.size()); else passed++;
    for (int k = 0; k < exp.size() && k < bus_log.size(); k++) begin
      checks++; if (bus_log[k] !== exp[k]) $display("FAIL config_nib%0d: got %h want %h", k, bus_log[k], exp[k]); else passed++;
    end
    clear_logs();
    run_req(3'd4, 20'h0, 5'd0, fin);
    checks++; if (!fin || bus_log.size() != 2) $display("FAIL resetop_len: got %0d want 2", bus_log.size()); else passed++;
    if (bus_log.size() == 2) begin
      checks++; if (bus_log[0] !== 5'h09 || bus_log[1] !== 5'h00)
        $display("FAIL resetop_seq: got %h,%h want 09,00", bus_log[0], bus_log[1]); else passed++;
    end
    checks++; if (o_pc !== 20'h1A2B5) $display("FAIL ops_pc: got %h want 1a2b5", o_pc); else passed++;
  endtask

  task automatic test_illegal();
    logic [2:0] ops[4];
    logic [4:0] lens[4];
    ops  = '{3'd5, 3'd1, 3'd2, 3'd7};
    lens = '{5'd1, 5'd0, 5'd17, 5'd3};
    for (int v = 0; v < 4; v++) begin
      clear_logs();
      i_req = 1'b1; i_req_op = ops[v]; i_req_addr = 20'h00ABC; i_req_len = lens[v];
      step();
      i_req = 1'b0;
      step(); step();
      checks++; if (err_cnt != 1 || o_req_ready !== 1'b1 || o_busy !== 1'b0 || bus_log.size() != 0)
        $display("FAIL illegal%0d: got err=%0d ready=%b busy=%b strobes=%0d want 1/1/0/0",
                 v, err_cnt, o_req_ready, o_busy, bus_log.size());
      else passed++;
    end
  endtask

  task automatic test_max_burst_wrap();
    bit fin;
    clear_logs();
    run_req(3'd1, 20'hFFFFF, 5'd16, fin);
    checks++; if (!fin || rd_log.size() != 16) $display("FAIL burst16: got valids=%0d want 16", rd_log.size()); else passed++;
    checks++; if (o_dp !== 20'h0000F) $display("FAIL dp_wrap: got %h want 0000f", o_dp); else passed++;
    clear_logs();
    run_req(3'd0, 20'hFFFFF, 5'd0, fin);
    i_fetch_ready = 1'b1; step(); i_fetch_ready = 1'b0; step();
    checks++; if (!fin || o_pc !== 20'h00000) $display("FAIL pc_wrap: got %h want 00000", o_pc); else passed++;
  endtask

  task automatic test_reset_mid_write();
    logic pre;
    bit   found;
    clear_logs();
    wr_q = '{4'h1, 4'h2, 4'h3, 4'h4};
    i_req = 1'b1; i_req_op = 3'd2; i_req_addr = 20'h00300; i_req_len = 5'd4;
    step();
    i_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (o_wr_pop) found = 1'b1;
    end
    checks++; if (!found) $display("FAIL midwr_timeout: got no pop want pop"); else passed++;
    step();
    pre = o_bus_strobe;
    done_cnt = 0;
    i_reset = 1'b1;
    #1;
    checks++; if (pre !== 1'b1 || o_bus_strobe !== 1'b0 || o_bus_cmd_data !== 1'b1)
      $display("FAIL midwr_async: got pre=%b strobe=%b cd=%b want 1/0/1", pre, o_bus_strobe, o_bus_cmd_data); else passed++;
    checks++; if (o_busy !== 1'b0 || o_pc !== 20'h0 || o_dp !== 20'h0)
      $display("FAIL midwr_clear: got busy=%b pc=%h dp=%h want 0", o_busy, o_pc, o_dp); else passed++;
    step(); step();
    clear_logs();
    i_reset = 1'b0;
    step(); step(); step();
    checks++; if (bus_log.size() != 1) $display("FAIL restart_len: got %0d want 1", bus_log.size()); else passed++;
    if (bus_log.size() >= 1) begin
      checks++; if (bus_log[0] !== 5'h00) $display("FAIL restart_cmd: got %h want 00", bus_log[0]); else passed++;
    end
    checks++; if (done_cnt != 0) $display("FAIL restart_done: got %0d want 0", done_cnt); else passed++;
    i_fetch_ready = 1'b1; step(); i_fetch_ready = 1'b0; step();
    checks++; if (o_pc !== 20'h1) $display("FAIL restart_pc: got %h want 1", o_pc); else passed++;
  endtask

  initial begin
    i_reset = 1'b1; i_bus_slot = 1'b1; i_req = 1'b0; i_fetch_ready = 1'b1;
    i_req_op = 3'd0; i_req_addr = 20'h0; i_req_len = 5'd0;
    i_wr_nibble = 4'h0; i_bus_data = 4'h6;
    done_cnt = 0; err_cnt = 0; pop_cnt = 0;
    test_reset();
    test_fetch_stall();
    test_jump();
    test_dwrite();
    test_dread();
    test_config_reset_ops();
    test_illegal();
    test_max_burst_wrap();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
